// File: rtl/boa_peri_baudgen_if.sv
// Peripheral memory bus shared by the boa_peri_* slaves.
// addr is a word address; rdata/ready are driven by the slave.
interface boa_mem_bus;
  logic [29:0] addr;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic        re;
  logic [31:0] rdata;
  logic        ready;

  modport MEM (input addr, we, wdata, re, output rdata, ready);
  modport CPU (output addr, we, wdata, re, input rdata, ready);
endinterface

// File: rtl/boa_peri_baudgen.sv
// Fractional baud clock generator: a 16.8 fixed-point divisor sets the
// average uart_clk period; divisor changes only land at period boundaries.
module boa_peri_baudgen #(
  parameter logic [31:0] addr        = 32'h8000_0010,
  parameter logic [23:0] default_div = 24'h000A2C,
  parameter bit          default_en  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  boa_mem_bus.MEM    bus,
  output logic       uart_clk,
  output logic       tick
);

  localparam logic [23:0] MIN_DIV = 24'h000200;

  function automatic logic [23:0] clamp_div(input logic [23:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

  localparam logic [23:0] RESET_DIV = clamp_div(default_div);
  localparam logic [29:0] BASE_W    = addr[31:2];

  logic [23:0] div_shadow;
  logic [23:0] div_active;
  logic        en;
  logic [24:0] acc;
  logic [15:0] pcount;
  logic [31:0] rdata_q;

  logic        sel_div, sel_ctrl, sel_stat;
  logic        div_wr, ctrl_wr;
  logic [23:0] div_merged, shadow_next;
  logic        en_next, restart;
  logic [24:0] s;
  logic        hit;
  logic [31:0] rd_val;
  logic        unused_bits;

  assign bus.ready   = 1'b1;
  assign bus.rdata   = rdata_q;
  assign unused_bits = ^{bus.wdata[31:24], bus.we[3]};

  // Address decode, byte-lane merge, control decode and read mux
  always_comb begin
    sel_div  = (bus.addr == BASE_W);
    sel_ctrl = (bus.addr == BASE_W + 30'd1);
    sel_stat = (bus.addr == BASE_W + 30'd2);

    div_merged = div_shadow;
    for (int unsigned i = 0; i < 3; i++) begin
      if (bus.we[i]) div_merged[8*i +: 8] = bus.wdata[8*i +: 8];
    end
    div_wr      = sel_div && (|bus.we);
    shadow_next = div_wr ? clamp_div(div_merged) : div_shadow;

    // EN and RESTART both live in byte lane 0
    ctrl_wr = sel_ctrl && bus.we[0];
    en_next = ctrl_wr ? bus.wdata[0] : en;
    restart = ctrl_wr && bus.wdata[1];

    s   = acc + 25'd512;
    hit = (s >= {1'b0, div_active});

    rd_val = '0;
    if (bus.re) begin
      if (sel_div)       rd_val = {8'h00, div_shadow};
      else if (sel_ctrl) rd_val = {31'b0, en};
      else if (sel_stat) rd_val = {pcount, 14'b0, (div_shadow != div_active), uart_clk};
    end
  end

  // Register file, phase accumulator and generated clock
  always_ff @(posedge clk) begin
    if (rst) begin
      div_shadow <= RESET_DIV;
      div_active <= RESET_DIV;
      en         <= default_en;
      acc        <= '0;
      uart_clk   <= 1'b0;
      tick       <= 1'b0;
      pcount     <= '0;
      rdata_q    <= '0;
    end else begin
      div_shadow <= shadow_next;
      en         <= en_next;
      rdata_q    <= rd_val;
      // Idle, disable and restart all park the generator low with acc cleared;
      // a DIV write cannot share a cycle with a CTRL write, so while running
      // shadow_next equals div_shadow here.
      if (!en || !en_next || restart) begin
        acc        <= '0;
        uart_clk   <= 1'b0;
        tick       <= 1'b0;
        div_active <= shadow_next;
      end else if (hit) begin
        acc      <= s - {1'b0, div_active};
        uart_clk <= ~uart_clk;
        tick     <= ~uart_clk;
        if (uart_clk) begin
          div_active <= div_shadow;
          pcount     <= pcount + 16'd1;
        end
      end else begin
        acc  <= s;
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_boa_peri_baudgen.sv
// Self-checking bench for boa_peri_baudgen: register vector table,
// directed multi-cycle sequences, then random bus traffic against a
// closed-form phase model.
module tb_boa_peri_baudgen;

  localparam logic [29:0] BASE_W = 30'h2000_0004;

  logic clk;
  logic rst;
  logic uart_clk;
  logic tick;

  boa_mem_bus bus_i ();

  boa_peri_baudgen #(
    .addr        (32'h8000_0010),
    .default_div (24'h000A2C),
    .default_en  (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_i),
    .uart_clk (uart_clk),
    .tick     (tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int off, input logic [3:0] we, input logic [31:0] d);
    bus_i.addr  = BASE_W + 30'(off);
    bus_i.we    = we;
    bus_i.wdata = d;
    bus_i.re    = 1'b0;
    cyc();
    bus_i.we    = '0;
  endtask

  task automatic rd(input int off, output logic [31:0] d);
    bus_i.addr = BASE_W + 30'(off);
    bus_i.we   = '0;
    bus_i.re   = 1'b1;
    cyc();
    d          = bus_i.rdata;
    bus_i.re   = 1'b0;
  endtask

  // ---------------- behavioural reference model ----------------
  // Within a segment (started with uart_clk low and remainder a0 under
  // divisor D) the toggle count after n cycles is floor((a0 + 512n)/D);
  // the second toggle closes the period and opens a new segment.
  bit          m_en;
  logic [23:0] m_shadow, m_active;
  longint      m_a0;
  longint      m_n;
  logic [15:0] m_pc;
  bit          m_clk, m_tick;

  task automatic m_reset();
    m_en = 1'b1; m_shadow = 24'h000A2C; m_active = 24'h000A2C;
    m_a0 = 0; m_n = 0; m_pc = '0; m_clk = 1'b0; m_tick = 1'b0;
  endtask

  task automatic m_park();
    m_a0 = 0; m_n = 0; m_clk = 1'b0; m_tick = 1'b0;
  endtask

  task automatic m_step(input int off, input logic [3:0] we, input logic [31:0] wd,
                        input logic re, output logic [31:0] exp_rd);
    logic [23:0] merged, sh_new;
    bit     div_wr, ctrl_wr, en_new, rs;
    longint pos, t, tp, d;
    exp_rd = '0;
    if (re) begin
      case (off)
        0: exp_rd = {8'h00, m_shadow};
        1: exp_rd = {31'b0, m_en};
        2: exp_rd = {m_pc, 14'b0, (m_shadow != m_active), m_clk};
        default: exp_rd = '0;
      endcase
    end
    div_wr  = (off == 0) && (we != 4'b0);
    ctrl_wr = (off == 1) && we[0];
    merged  = m_shadow;
    if (we[0]) merged[7:0]   = wd[7:0];
    if (we[1]) merged[15:8]  = wd[15:8];
    if (we[2]) merged[23:16] = wd[23:16];
    if (merged < 24'h000200) merged = 24'h000200;
    sh_new = div_wr ? merged : m_shadow;
    en_new = ctrl_wr ? wd[0] : m_en;
    rs     = ctrl_wr && wd[1];
    if (!m_en) begin
      m_park(); m_active = sh_new;
    end else if (!en_new || rs) begin
      m_park(); m_active = m_shadow;
    end else begin
      m_n++;
      d   = longint'(m_active);
      pos = m_a0 + 512 * m_n;
      t   = pos / d;
      tp  = (pos - 512) / d;
      m_tick = (t == 1) && (tp == 0);
      m_clk  = (t == 1);
      if (t >= 2) begin
        m_a0 = pos - 2 * d; m_n = 0; m_active = m_shadow; m_pc++; m_clk = 1'b0;
      end
    end
    m_shadow = sh_new;
    m_en     = en_new;
  endtask

  // ---------------- register vector table ----------------
  typedef struct {
    int          off;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic        re;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic [31:0] d, s1, s2;
    int lo, hi, nt, bad, guard;
    bit prev;

    tbl[0]  = '{0, 4'h0, 32'h0,        1'b1, 32'h0000_0A2C};
    tbl[1]  = '{1, 4'h0, 32'h0,        1'b1, 32'h0000_0001};
    tbl[2]  = '{2, 4'h0, 32'h0,        1'b1, 32'h0000_0000};
    tbl[3]  = '{0, 4'hF, 32'h0000_0100, 1'b0, 32'h0};
    tbl[4]  = '{0, 4'h0, 32'h0,        1'b1, 32'h0000_0200};
    tbl[5]  = '{0, 4'h1, 32'hFFFF_FF55, 1'b0, 32'h0};
    tbl[6]  = '{0, 4'h0, 32'h0,        1'b1, 32'h0000_0255};
    tbl[7]  = '{0, 4'hF, 32'hFFAB_CDEF, 1'b0, 32'h0};
    tbl[8]  = '{0, 4'h0, 32'h0,        1'b1, 32'h00AB_CDEF};
    tbl[9]  = '{0, 4'h6, 32'h0012_3400, 1'b1, 32'h00AB_CDEF};
    tbl[10] = '{0, 4'h0, 32'h0,        1'b1, 32'h0012_34EF};
    tbl[11] = '{3, 4'h0, 32'h0,        1'b1, 32'h0};
    tbl[12] = '{0, 4'h0, 32'h0,        1'b0, 32'h0};

    bus_i.addr = '0; bus_i.we = '0; bus_i.wdata = '0; bus_i.re = 1'b0;
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    check("reset_uart_clk", {31'b0, uart_clk}, 32'h0);
    check("reset_tick", {31'b0, tick}, 32'h0);
    check("reset_rdata", bus_i.rdata, 32'h0);
    check("ready", {31'b0, bus_i.ready}, 32'h1);

    for (int i = 0; i < 13; i++) begin
      bus_i.addr  = BASE_W + 30'(tbl[i].off);
      bus_i.we    = tbl[i].we;
      bus_i.wdata = tbl[i].wdata;
      bus_i.re    = tbl[i].re;
      cyc();
      check($sformatf("vec%0d_rdata", i), bus_i.rdata, tbl[i].exp);
    end
    bus_i.we = '0; bus_i.re = 1'b0;

    // DIV 4.0: 2 high / 2 low, one period per 4 cycles
    wr(0, 4'hF, 32'h0000_0400);
    wr(1, 4'h1, 32'h0000_0003);
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      if (uart_clk !== 1'((k / 2) % 2)) bad++;
      if (tick !== (k % 4 == 2)) bad++;
      cyc();
    end
    check("div4_waveform_errs", 32'(bad), 32'h0);
    rd(2, s1);
    repeat (39) cyc();
    rd(2, s2);
    check("div4_pcount_delta", {16'h0, s2[31:16] - s1[31:16]}, 32'd10);

    // DIV 3.0: toggle intervals 2,1; 100 periods in 300 cycles
    wr(0, 4'hF, 32'h0000_0300);
    wr(1, 4'h1, 32'h0000_0003);
    bad = 0; nt = 0;
    for (int k = 0; k < 300; k++) begin
      if (tick === 1'b1) nt++;
      if (k < 12 && uart_clk !== (k % 3 == 2)) bad++;
      cyc();
    end
    check("div3_ticks_300", 32'(nt), 32'd100);
    check("div3_pattern_errs", 32'(bad), 32'h0);

    // DIV below minimum clamps to 2.0: toggles every cycle
    wr(0, 4'hF, 32'h0000_0100);
    wr(1, 4'h1, 32'h0000_0003);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (uart_clk !== 1'(k % 2)) bad++;
      cyc();
    end
    check("div2_toggle_errs", 32'(bad), 32'h0);

    // Pending divisor change lands cleanly at the next falling edge
    wr(0, 4'hF, 32'h0000_0400);
    wr(1, 4'h1, 32'h0000_0003);
    repeat (5) cyc();
    wr(0, 4'hF, 32'h0000_0800);
    rd(2, d);
    check("pending_set", {31'b0, d[1]}, 32'h1);
    prev = uart_clk;
    guard = 0;
    while (guard < 20) begin
      cyc();
      guard++;
      if (prev && !uart_clk) break;
      prev = uart_clk;
    end
    check("fall_found", {31'b0, (guard < 20)}, 32'h1);
    lo = 0;
    while (uart_clk === 1'b0 && lo < 40) begin lo++; cyc(); end
    hi = 0;
    while (uart_clk === 1'b1 && hi < 40) begin hi++; cyc(); end
    check("div8_low_cycles", 32'(lo), 32'd4);
    check("div8_high_cycles", 32'(hi), 32'd4);
    rd(2, d);
    check("pending_clear", {31'b0, d[1]}, 32'h0);

    // Disable mid-high: clock drops, no period counted, tick silent
    guard = 0;
    while (tick !== 1'b1 && guard < 40) begin cyc(); guard++; end
    check("tick_found", {31'b0, tick}, 32'h1);
    rd(2, s1);
    check("status_clk_high", {31'b0, s1[0]}, 32'h1);
    wr(1, 4'h1, 32'h0000_0000);
    check("disable_clk_low", {31'b0, uart_clk}, 32'h0);
    rd(2, s2);
    check("disable_pcount_same", {16'h0, s2[31:16]}, {16'h0, s1[31:16]});
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (uart_clk !== 1'b0 || tick !== 1'b0) bad++;
      cyc();
    end
    check("disabled_quiet_errs", 32'(bad), 32'h0);
    wr(1, 4'h1, 32'h0000_0001);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (uart_clk !== (k == 4)) bad++;
      cyc();
    end
    check("enable_first_rise_errs", 32'(bad), 32'h0);

    // Reset while uart_clk is high
    guard = 0;
    while (uart_clk !== 1'b1 && guard < 40) begin cyc(); guard++; end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst_clk_low", {31'b0, uart_clk}, 32'h0);
    rd(2, d);
    check("rst_status", d, 32'h0);
    rd(0, d);
    check("rst_div", d, 32'h0000_0A2C);

    // Random traffic against the model
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    m_reset();
    for (int c = 0; c < 4000; c++) begin
      int r, off;
      logic [3:0]  we;
      logic [31:0] wd, exp_rd;
      logic        re;
      r = $urandom_range(0, 99);
      off = $urandom_range(0, 3);
      we = '0; re = 1'b0; wd = $urandom;
      if (r < 6) begin
        off = 0;
        we  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
        wd  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 24'h1400));
      end else if (r < 9) begin
        off = 1;
        we  = ($urandom_range(0, 5) == 0) ? 4'h2 : 4'h1;
        wd  = {30'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0)};
      end else if (r < 40) begin
        re = 1'b1;
      end
      bus_i.addr = BASE_W + 30'(off);
      bus_i.we = we; bus_i.wdata = wd; bus_i.re = re;
      m_step(off, we, wd, re, exp_rd);
      cyc();
      check("rand_uart_clk", {31'b0, uart_clk}, {31'b0, m_clk});
      check("rand_tick", {31'b0, tick}, {31'b0, m_tick});
      check("rand_rdata", bus_i.rdata, exp_rd);
    end
    bus_i.we = '0; bus_i.re = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
